// File: rtl/frame_timer_bank.sv
// frame_timer_bank: one shared frame prescaler driving NUM_CH independent one-shot/periodic frame down-counters.
// Define FRAME_TIMER_IRQ_EN to add sticky per-channel irq_pending (write-one-to-clear) and an OR'd irq.
module frame_timer_bank #(
  parameter int CLKS_PER_FRAME = 833334,
  parameter int NUM_CH         = 4,
  parameter int CNT_W          = 8,
  localparam int IDX_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 load_en,
  input  logic [IDX_W-1:0]     load_ch,
  input  logic [CNT_W-1:0]     load_val,
  input  logic                 load_periodic,
  input  logic                 stop_en,
  input  logic [IDX_W-1:0]     stop_ch,
  input  logic [IDX_W-1:0]     rd_ch,
`ifdef FRAME_TIMER_IRQ_EN
  input  logic [NUM_CH-1:0]    irq_clr,
  output logic [NUM_CH-1:0]    irq_pending,
  output logic                 irq,
`endif
  output logic [CNT_W-1:0]     rd_count,
  output logic                 frame_tick,
  output logic [NUM_CH-1:0]    active,
  output logic [NUM_CH-1:0]    expire
);

  localparam int              PS_W    = $clog2(CLKS_PER_FRAME);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLKS_PER_FRAME - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [PS_W-1:0] ps_q;
  logic            tick;

  assign tick = enable && (ps_q == PS_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      ps_q       <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= tick;
      if (enable) begin
        ps_q <= (ps_q == PS_LAST) ? '0 : ps_q + PS_W'(1);
      end
    end
  end

  logic [NUM_CH-1:0][0:0]       st_q,   st_d;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q,  cnt_d;
  logic [NUM_CH-1:0][CNT_W-1:0] rel_q,  rel_d;
  logic [NUM_CH-1:0]            per_q,  per_d;
  logic [NUM_CH-1:0]            exp_d;

  // Per-channel next state; load beats stop beats tick on the same channel.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    st_d  = st_q;
    cnt_d = cnt_q;
    rel_d = rel_q;
    per_d = per_q;
    exp_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (load_en && (load_ch == IDX_W'(i))) begin
        if (load_val != '0) begin
          st_d[i]  = ST_RUN;
          cnt_d[i] = load_val;
          rel_d[i] = load_val;
          per_d[i] = load_periodic;
        end else begin
          st_d[i]  = ST_IDLE;
          cnt_d[i] = '0;
        end
      end else if (stop_en && (stop_ch == IDX_W'(i))) begin
        st_d[i]  = ST_IDLE;
        cnt_d[i] = '0;
      end else if (tick && (st_q[i] == ST_RUN)) begin
        if (cnt_q[i] > CNT_W'(1)) begin
          cnt_d[i] = cnt_q[i] - CNT_W'(1);
        end else begin
          exp_d[i] = 1'b1;
          if (per_q[i]) begin
            cnt_d[i] = rel_q[i];
          end else begin
            cnt_d[i] = '0;
            st_d[i]  = ST_IDLE;
          end
        end
      end
    end
  end

  // NOTE: the channel register file is small and must read as zero after reset, so all of it is reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      st_q   <= '0;
      cnt_q  <= '0;
      rel_q  <= '0;
      per_q  <= '0;
      expire <= '0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      rel_q  <= rel_d;
      per_q  <= per_d;
      expire <= exp_d;
    end
  end

  always_comb begin
    active   = '0;
    rd_count = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      active[i] = (st_q[i] == ST_RUN);
      if (rd_ch == IDX_W'(i)) begin
        rd_count = cnt_q[i];
      end
    end
  end

`ifdef FRAME_TIMER_IRQ_EN
  // A fresh expiry sets pending even if software clears it in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      irq_pending <= '0;
    end else begin
      irq_pending <= (irq_pending & ~irq_clr) | expire;
    end
  end

  assign irq = |irq_pending;
`endif

endmodule

// File: tb/tb_frame_timer_bank.sv
// Self-checking bench for frame_timer_bank: a per-cycle spec model queues expected expiry tick ordinals per channel.
// A second instance with NUM_CH = 3 exercises out-of-range channel indices, which a 2-bit index cannot express for 4 channels.
module tb_frame_timer_bank;

  localparam int CPF = 4;
  localparam int NCH = 4;
  localparam int CW  = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic          load_en;
  logic [1:0]    load_ch;
  logic [CW-1:0] load_val;
  logic          load_periodic;
  logic          stop_en;
  logic [1:0]    stop_ch;
  logic [1:0]    rd_ch;
  logic [CW-1:0] rd_count;
  logic          frame_tick;
  logic [NCH-1:0] active;
  logic [NCH-1:0] expire;

  logic          o_load_en;
  logic [1:0]    o_load_ch;
  logic [CW-1:0] o_load_val;
  logic          o_stop_en;
  logic [1:0]    o_stop_ch;
  logic [1:0]    o_rd_ch;
  logic [CW-1:0] o_rd_count;
  logic          o_frame_tick;
  logic [2:0]    o_active;
  logic [2:0]    o_expire;

`ifdef FRAME_TIMER_IRQ_EN
  logic [NCH-1:0] irq_clr;
  logic [NCH-1:0] irq_pending;
  logic           irq;
  logic [2:0]     o_irq_pending;
  logic           o_irq;
`endif

  always #5 clock = ~clock;

  frame_timer_bank #(.CLKS_PER_FRAME(CPF), .NUM_CH(NCH), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .load_en(load_en), .load_ch(load_ch), .load_val(load_val), .load_periodic(load_periodic),
    .stop_en(stop_en), .stop_ch(stop_ch), .rd_ch(rd_ch),
`ifdef FRAME_TIMER_IRQ_EN
    .irq_clr(irq_clr), .irq_pending(irq_pending), .irq(irq),
`endif
    .rd_count(rd_count), .frame_tick(frame_tick), .active(active), .expire(expire)
  );

  frame_timer_bank #(.CLKS_PER_FRAME(CPF), .NUM_CH(3), .CNT_W(CW)) u_odd (
    .clock(clock), .reset(reset), .enable(1'b0),
    .load_en(o_load_en), .load_ch(o_load_ch), .load_val(o_load_val), .load_periodic(1'b0),
    .stop_en(o_stop_en), .stop_ch(o_stop_ch), .rd_ch(o_rd_ch),
`ifdef FRAME_TIMER_IRQ_EN
    .irq_clr(3'b000), .irq_pending(o_irq_pending), .irq(o_irq),
`endif
    .rd_count(o_rd_count), .frame_tick(o_frame_tick), .active(o_active), .expire(o_expire)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Spec model state
  int             cyc     = 0;
  int             ps_m    = 0;
  bit             ft_m    = 0;
  int             mtick_n = 0;
  logic [NCH-1:0] act_m   = '0;
  logic [NCH-1:0] exp_m   = '0;
  logic [NCH-1:0] per_m   = '0;
  logic [NCH-1:0] pend_m  = '0;
  int             rel_m [NCH];
  int             exp_q [NCH][$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, want);
    end
  endtask

  // One clock: advance the model with the inputs that the edge consumes, then compare.
  task automatic step();
    bit             pend;
    logic [NCH-1:0] prev_exp;
    pend     = enable && (ps_m == CPF - 1);
    prev_exp = exp_m;
    @(posedge clock);
    #1;
    cyc++;
    if (reset) begin
      ps_m   = 0;
      ft_m   = 0;
      exp_m  = '0;
      act_m  = '0;
      per_m  = '0;
      pend_m = '0;
      for (int i = 0; i < NCH; i++) exp_q[i].delete();
    end else begin
      ft_m = pend;
      if (enable) ps_m = (ps_m == CPF - 1) ? 0 : ps_m + 1;
      if (ft_m) mtick_n++;
`ifdef FRAME_TIMER_IRQ_EN
      pend_m = (pend_m & ~irq_clr) | prev_exp;
`endif
      exp_m = '0;
      for (int i = 0; i < NCH; i++) begin
        if (load_en && load_ch == i) begin
          exp_q[i].delete();
          if (load_val != 0) begin
            act_m[i] = 1'b1;
            per_m[i] = load_periodic;
            rel_m[i] = int'(load_val);
            exp_q[i].push_back(mtick_n + int'(load_val));
          end else begin
            act_m[i] = 1'b0;
          end
        end else if (stop_en && stop_ch == i) begin
          exp_q[i].delete();
          act_m[i] = 1'b0;
        end else if (ft_m && exp_q[i].size() != 0 && exp_q[i][0] == mtick_n) begin
          exp_m[i] = 1'b1;
          void'(exp_q[i].pop_front());
          if (per_m[i]) exp_q[i].push_back(mtick_n + rel_m[i]);
          else          act_m[i] = 1'b0;
        end
      end
    end
    check("frame_tick", frame_tick, ft_m);
    for (int i = 0; i < NCH; i++) begin
      check($sformatf("expire%0d", i), expire[i], exp_m[i]);
      check($sformatf("active%0d", i), active[i], act_m[i]);
    end
`ifdef FRAME_TIMER_IRQ_EN
    check("irq_pending", irq_pending, pend_m);
    check("irq", irq, |pend_m);
`endif
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic wait_tick();
    int n = 0;
    do begin
      step();
      n++;
    end while (!ft_m && n < 20);
    if (!ft_m) check("tick_timeout", 0, 1);
  endtask

  // Stop one cycle before a tick edge so the next driven request coincides with it.
  task automatic wait_pending();
    int n = 0;
    while (!(enable && ps_m == CPF - 1) && n < 20) begin
      step();
      n++;
    end
    if (!(enable && ps_m == CPF - 1)) check("pending_timeout", 0, 1);
  endtask

  task automatic check_rd(input int ch, input int want);
    rd_ch = 2'(ch);
    #1;
    check($sformatf("rd_count%0d", ch), rd_count, want);
  endtask

  task automatic do_load(input int ch, input int val, input bit periodic);
    load_en       = 1'b1;
    load_ch       = 2'(ch);
    load_val      = CW'(val);
    load_periodic = periodic;
    step();
    load_en       = 1'b0;
  endtask

  task automatic do_stop(input int ch);
    stop_en = 1'b1;
    stop_ch = 2'(ch);
    step();
    stop_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b0;
    load_en = 1'b0; load_ch = '0; load_val = '0; load_periodic = 1'b0;
    stop_en = 1'b0; stop_ch = '0; rd_ch = '0;
    o_load_en = 1'b0; o_load_ch = '0; o_load_val = '0;
    o_stop_en = 1'b0; o_stop_ch = '0; o_rd_ch = '0;
`ifdef FRAME_TIMER_IRQ_EN
    irq_clr = '0;
`endif

    // Reset and tick rate
    steps(3);
    for (int c = 0; c < NCH; c++) check_rd(c, 0);
    reset  = 1'b0;
    enable = 1'b1;
    steps(14);

    // One-shot ch0 = 3: counts 3,2,1,0 with expire on the third tick
    wait_tick();
    do_load(0, 3, 1'b0);
    check_rd(0, 3);
    for (int k = 2; k >= 0; k--) begin
      wait_tick();
      check_rd(0, k);
    end

    // Periodic ch1 = 2 and ch2 = 4 run concurrently
    wait_tick();
    do_load(1, 2, 1'b1);
    do_load(2, 4, 1'b1);
    steps(40);

    // Load beats tick: ch3 at count 1 reloaded to 5 on the tick edge
    wait_tick();
    do_load(3, 1, 1'b0);
    wait_pending();
    do_load(3, 5, 1'b0);
    check_rd(3, 5);
    steps(3);
    // Load beats stop
    load_en = 1'b1; load_ch = 2'd3; load_val = 8'd2; load_periodic = 1'b0;
    stop_en = 1'b1; stop_ch = 2'd3;
    step();
    load_en = 1'b0; stop_en = 1'b0;
    check_rd(3, 2);
    // Stop beats tick on ch1
    wait_pending();
    do_stop(1);
    check_rd(1, 0);
    steps(12);

    // Enable low mid-frame freezes prescaler and counts
    wait_tick();
    do_load(0, 3, 1'b0);
    step();
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check_rd(0, 3);
    end
    enable = 1'b1;
    steps(16);

    // Load with value 0 idles a running channel and leaves an idle one idle
    do_load(2, 0, 1'b1);
    check_rd(2, 0);
    do_load(0, 0, 1'b0);
    steps(8);

    // Out-of-range indices on the 3-channel instance
    o_load_en = 1'b1; o_load_ch = 2'd3; o_load_val = 8'd7;
    step();
    o_load_en = 1'b0;
    check("odd_active_oor_load", o_active, 3'b000);
    o_load_en = 1'b1; o_load_ch = 2'd2; o_load_val = 8'd9;
    step();
    o_load_en = 1'b0;
    o_stop_en = 1'b1; o_stop_ch = 2'd3;
    step();
    o_stop_en = 1'b0;
    check("odd_active_oor_stop", o_active, 3'b100);
    o_rd_ch = 2'd2;
    #1 check("odd_rd_count2", o_rd_count, 9);
    o_rd_ch = 2'd3;
    #1 check("odd_rd_count_oor", o_rd_count, 0);
    check("odd_no_tick", {o_frame_tick, o_expire}, 4'b0000);

    // Reset while ch0 runs aborts everything
    do_load(0, 5, 1'b0);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int c = 0; c < NCH; c++) check_rd(c, 0);
    check("odd_active_after_reset", o_active, 3'b000);
    steps(4);

`ifdef FRAME_TIMER_IRQ_EN
    // Sticky pending until cleared
    wait_tick();
    do_load(0, 1, 1'b0);
    wait_tick();
    steps(5);
    check("irq_pending0_held", irq_pending[0], 1'b1);
    irq_clr = 4'b0001;
    step();
    irq_clr = '0;
    check("irq_pending0_cleared", irq_pending[0], 1'b0);
    // Clear coinciding with a new expiry: set wins
    do_load(0, 1, 1'b1);
    wait_tick();
    irq_clr = 4'b0001;
    step();
    irq_clr = '0;
    check("irq_set_wins", irq_pending[0], 1'b1);
    steps(6);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
